// File: rtl/plic_gateway.sv
// Per-source PLIC interrupt gateway: trigger detection, pending/in-flight tracking
// and queued-edge counting between claim and complete.
module plic_gateway #(
    parameter int NSRC  = 8,
    parameter int CNT_W = 3,
    parameter int ID_W  = $clog2(NSRC + 1)
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic [NSRC-1:0]     irq_src,
    input  logic [2*NSRC-1:0]   trig_mode,
    input  logic                claim_vld,
    input  logic [ID_W-1:0]     claim_id,
    input  logic                complete_vld,
    input  logic [ID_W-1:0]     complete_id,
    output logic [NSRC-1:0]     ip,
    output logic [NSRC-1:0]     ovf
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PEND     = 2'd1,
        S_INFLIGHT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        localparam logic [ID_W-1:0] SRC_ID = ID_W'(g + 1);

        state_t           r_state;
        state_t           w_state_nxt;
        logic             r_src_q;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_ovf;
        logic             w_ovf_nxt;
        logic [1:0]       w_mode;
        logic             w_level;
        logic             w_trig;
        logic             w_inc;
        logic             w_claim;
        logic             w_complete;
        logic [CNT_W:0]   w_cnt_sum;
        logic             w_ip;

        assign w_mode  = trig_mode[2*g+1 : 2*g];
        assign w_level = ~w_mode[1];

        // NOTE: every always_comb output gets a default first so no latch is inferred.
        always_comb begin
            w_trig = 1'b0;
            case (w_mode)
                2'b00:   w_trig =  irq_src[g];
                2'b01:   w_trig = ~irq_src[g];
                2'b10:   w_trig =  irq_src[g] & ~r_src_q;
                2'b11:   w_trig = ~irq_src[g] &  r_src_q;
                default: w_trig = 1'b0;
            endcase
        end

        // Claims and completes only count when addressed here and legal for the state.
        assign w_claim    = claim_vld    && (claim_id    == SRC_ID) && (r_state == S_PEND);
        assign w_complete = complete_vld && (complete_id == SRC_ID) && (r_state == S_INFLIGHT);
        assign w_inc      = w_trig && !w_level && (r_state != S_IDLE);
        assign w_cnt_sum  = {1'b0, r_cnt} + (CNT_W+1)'(w_inc);

        // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
        always_ff @(posedge pclk or negedge preset_n) begin
            if (!preset_n) begin
                r_state <= S_IDLE;
                r_src_q <= 1'b0;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_src_q <= irq_src[g];
                r_cnt   <= w_cnt_nxt;
                r_ovf   <= w_ovf_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                S_IDLE: begin
                    if (w_trig) w_state_nxt = S_PEND;
                end
                S_PEND: begin
                    if (w_claim) w_state_nxt = S_INFLIGHT;
                end
                S_INFLIGHT: begin
                    if (w_complete) begin
                        if (w_level) w_state_nxt = w_trig ? S_PEND : S_IDLE;
                        else         w_state_nxt = (w_cnt_sum != '0) ? S_PEND : S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // Queued-edge counter: a complete consumes one unit of work, including an edge
        // arriving in the same cycle; otherwise edges accumulate and saturate.
        always_comb begin
            w_cnt_nxt = r_cnt;
            w_ovf_nxt = r_ovf;
            if (w_level) begin
                w_cnt_nxt = '0;
            end else if (w_complete) begin
                w_cnt_nxt = (w_cnt_sum != '0) ? CNT_W'(w_cnt_sum - (CNT_W+1)'(1)) : '0;
            end else if (w_inc) begin
                if (r_cnt == CNT_MAX) w_ovf_nxt = 1'b1;
                else                  w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end

        always_comb begin
            w_ip = (r_state == S_PEND);
        end

        assign ip[g]  = w_ip;
        assign ovf[g] = r_ovf;
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway: stimulus queues expected ip/ovf per cycle,
// a monitor pops and compares them on the falling edge.
module tb_plic_gateway;

    localparam int NSRC  = 8;
    localparam int CNT_W = 3;
    localparam int ID_W  = 4;

    logic              pclk = 1'b0;
    logic              preset_n;
    logic [NSRC-1:0]   irq_src;
    logic [2*NSRC-1:0] trig_mode;
    logic              claim_vld;
    logic [ID_W-1:0]   claim_id;
    logic              complete_vld;
    logic [ID_W-1:0]   complete_id;
    logic [NSRC-1:0]   ip;
    logic [NSRC-1:0]   ovf;

    plic_gateway #(.NSRC(NSRC), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .pclk         (pclk),
        .preset_n     (preset_n),
        .irq_src      (irq_src),
        .trig_mode    (trig_mode),
        .claim_vld    (claim_vld),
        .claim_id     (claim_id),
        .complete_vld (complete_vld),
        .complete_id  (complete_id),
        .ip           (ip),
        .ovf          (ovf)
    );

    always #5 pclk = ~pclk;

    int   cyc = 0;
    bit   done = 1'b0;
    event chk_now;

    always @(posedge pclk) cyc <= cyc + 1;

    int              stamp_q[$];
    logic [NSRC-1:0] eip_q[$];
    logic [NSRC-1:0] eovf_q[$];
    string           name_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [NSRC-1:0] a_ip, input logic [NSRC-1:0] a_ovf,
                         input logic [NSRC-1:0] e_ip, input logic [NSRC-1:0] e_ovf);
        n_checks++;
        if ({a_ip, a_ovf} !== {e_ip, e_ovf}) begin
            n_fail++;
            $display("FAIL %s: got ip=%h ovf=%h, expected ip=%h ovf=%h (cycle %0d)",
                     nm, a_ip, a_ovf, e_ip, e_ovf, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge pclk or chk_now);
            while (stamp_q.size() > 0 && stamp_q[0] <= cyc) begin
                check(name_q[0], ip, ovf, eip_q[0], eovf_q[0]);
                void'(stamp_q.pop_front());
                void'(eip_q.pop_front());
                void'(eovf_q.pop_front());
                void'(name_q.pop_front());
            end
            if (done) begin
                while (name_q.size() > 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: never compared, expected ip=%h ovf=%h", name_q[0], eip_q[0], eovf_q[0]);
                    void'(stamp_q.pop_front());
                    void'(eip_q.pop_front());
                    void'(eovf_q.pop_front());
                    void'(name_q.pop_front());
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic expect_at(input string nm, input logic [NSRC-1:0] e_ip,
                             input logic [NSRC-1:0] e_ovf, input int stamp);
        stamp_q.push_back(stamp);
        eip_q.push_back(e_ip);
        eovf_q.push_back(e_ovf);
        name_q.push_back(nm);
    endtask

    // Apply the currently driven inputs for one clock; outputs are expected after that edge.
    task automatic tick(input string nm, input logic [NSRC-1:0] e_ip, input logic [NSRC-1:0] e_ovf);
        expect_at(nm, e_ip, e_ovf, cyc + 1);
        @(posedge pclk);
        #1;
        claim_vld    = 1'b0;
        complete_vld = 1'b0;
    endtask

    task automatic do_claim(input int id);
        claim_vld = 1'b1;
        claim_id  = ID_W'(id);
    endtask

    task automatic do_complete(input int id);
        complete_vld = 1'b1;
        complete_id  = ID_W'(id);
    endtask

    logic [NSRC-1:0] ov;

    initial begin
        preset_n     = 1'b0;
        irq_src      = '0;
        trig_mode    = 16'hAAAA;
        claim_vld    = 1'b0;
        claim_id     = '0;
        complete_vld = 1'b0;
        complete_id  = '0;
        ov           = '0;
        #1;
        expect_at("reset", 8'h00, 8'h00, cyc);
        ->chk_now;
        @(posedge pclk);
        #1;
        preset_n = 1'b1;
        tick("idle", 8'h00, ov);

        // Single rising pulse on source 2 (ID 3).
        irq_src[2] = 1'b1;               tick("t1_pend",     8'h04, ov);
        irq_src[2] = 1'b0; do_claim(3);  tick("t1_claim",    8'h00, ov);
        do_complete(3);                  tick("t1_complete", 8'h00, ov);
        tick("t1_idle", 8'h00, ov);

        // Three edges queued while in flight, drained by three re-pends.
        irq_src[0] = 1'b1;               tick("t2_pend",  8'h01, ov);
        irq_src[0] = 1'b0; do_claim(1);  tick("t2_claim", 8'h00, ov);
        for (int k = 0; k < 3; k++) begin
            irq_src[0] = 1'b1; tick("t2_edge", 8'h00, ov);
            irq_src[0] = 1'b0; tick("t2_gap",  8'h00, ov);
        end
        for (int r = 0; r < 3; r++) begin
            do_complete(1); tick("t2_repend",  8'h01, ov);
            do_claim(1);    tick("t2_reclaim", 8'h00, ov);
        end
        do_complete(1); tick("t2_final", 8'h00, ov);

        // Nine edges against a 3-bit counter: saturation at 7, eighth edge overflows.
        irq_src[0] = 1'b1;               tick("t3_pend",  8'h01, ov);
        irq_src[0] = 1'b0; do_claim(1);  tick("t3_claim", 8'h00, ov);
        for (int k = 0; k < 9; k++) begin
            if (k == 7) ov = 8'h01;
            irq_src[0] = 1'b1; tick("t3_edge", 8'h00, ov);
            irq_src[0] = 1'b0; tick("t3_gap",  8'h00, ov);
        end
        for (int r = 0; r < 7; r++) begin
            do_complete(1); tick("t3_repend",  8'h01, ov);
            do_claim(1);    tick("t3_reclaim", 8'h00, ov);
        end
        do_complete(1); tick("t3_drain", 8'h00, ov);

        // Level-high on source 5 (ID 6), mode switched in the triggering cycle.
        trig_mode[11:10] = 2'b00; irq_src[5] = 1'b1; tick("t4_pend",    8'h20, ov);
        do_claim(6);                                 tick("t4_claim",   8'h00, ov);
        tick("t4_hold", 8'h00, ov);
        do_complete(6);                              tick("t4_repend",  8'h20, ov);
        do_claim(6);                                 tick("t4_reclaim", 8'h00, ov);
        irq_src[5] = 1'b0;                           tick("t4_drop",    8'h00, ov);
        do_complete(6);                              tick("t4_idle",    8'h00, ov);
        tick("t4_idle2", 8'h00, ov);
        irq_src[5] = 1'b1;                           tick("t4_pend2",   8'h20, ov);
        irq_src[5] = 1'b0;                           tick("t4_sticky",  8'h20, ov);
        do_claim(6);                                 tick("t4_claim2",  8'h00, ov);
        do_complete(6);                              tick("t4_idle3",   8'h00, ov);

        // Edge coincident with complete at cnt=0, then same-ID claim+complete.
        irq_src[0] = 1'b1;                  tick("t5_pend",      8'h01, ov);
        irq_src[0] = 1'b0; do_claim(1);     tick("t5_claim",     8'h00, ov);
        irq_src[0] = 1'b1; do_complete(1);  tick("t5_cmp_edge",  8'h01, ov);
        irq_src[0] = 1'b0; do_claim(1);     tick("t5_claim2",    8'h00, ov);
        do_complete(1);                     tick("t5_cnt0",      8'h00, ov);
        irq_src[0] = 1'b1;                  tick("t5_pend3",     8'h01, ov);
        irq_src[0] = 1'b0; do_claim(1);     tick("t5_claim3",    8'h00, ov);
        do_claim(1); do_complete(1);        tick("t5_same_infl", 8'h00, ov);
        irq_src[0] = 1'b1;                  tick("t5_idle_chk",  8'h01, ov);
        irq_src[0] = 1'b0; do_claim(1); do_complete(1); tick("t5_same_pend", 8'h00, ov);
        do_complete(1);                     tick("t5_close",     8'h00, ov);
        irq_src[0] = 1'b1; irq_src[2] = 1'b1; tick("t5_two",     8'h05, ov);
        irq_src[0] = 1'b0; irq_src[2] = 1'b0; do_claim(1); tick("t5_c1", 8'h04, ov);
        do_claim(3); do_complete(1);        tick("t5_diff",      8'h00, ov);
        do_complete(3);                     tick("t5_close3",    8'h00, ov);

        // Illegal and wrong-state requests on source 4 (ID 5).
        do_claim(5);                        tick("t6_claim_idle", 8'h00, ov);
        irq_src[4] = 1'b1;                  tick("t6_idle_pend",  8'h10, ov);
        irq_src[4] = 1'b0; do_complete(5);  tick("t6_cmp_pend",   8'h10, ov);
        do_claim(0);                        tick("t6_claim0",     8'h10, ov);
        do_claim(9);                        tick("t6_claim9",     8'h10, ov);
        do_claim(5);                        tick("t6_claim5",     8'h00, ov);
        do_complete(0);                     tick("t6_cmp0",       8'h00, ov);
        do_complete(9);                     tick("t6_cmp9",       8'h00, ov);
        irq_src[4] = 1'b1;                  tick("t6_infl_edge",  8'h00, ov);
        irq_src[4] = 1'b0; do_complete(5);  tick("t6_cmp5",       8'h10, ov);
        do_claim(5);                        tick("t6_reclaim",    8'h00, ov);
        do_complete(5);                     tick("t6_done",       8'h00, ov);

        // Source 0 in flight with four queued edges plus source 2 pending, then async reset.
        irq_src[0] = 1'b1;                  tick("t7_pend",  8'h01, ov);
        irq_src[0] = 1'b0; do_claim(1);     tick("t7_claim", 8'h00, ov);
        for (int k = 0; k < 4; k++) begin
            irq_src[0] = 1'b1; tick("t7_edge", 8'h00, ov);
            irq_src[0] = 1'b0; tick("t7_gap",  8'h00, ov);
        end
        irq_src[2] = 1'b1;                  tick("t7_src2",  8'h04, ov);
        irq_src[2] = 1'b0;
        @(negedge pclk);
        #1;
        preset_n = 1'b0;
        #1;
        expect_at("t7_async_reset", 8'h00, 8'h00, cyc);
        ->chk_now;

        // Release artefacts: src 1 high in rising mode, src 7 low in level-low mode.
        irq_src   = 8'h02;
        trig_mode = 16'h6AAA;
        ov        = '0;
        #1;
        preset_n = 1'b1;
        tick("t8_release", 8'h82, ov);
        do_claim(8);    tick("t8_claim8",   8'h02, ov);
        do_complete(8); tick("t8_repend8",  8'h82, ov);
        do_claim(2);    tick("t8_claim2",   8'h80, ov);
        do_complete(1); tick("t8_cmp_gone", 8'h80, ov);

        done = 1'b1;
    end

endmodule

// File: doc/plic_gateway.md
# plic_gateway

Per-source interrupt gateway for the PLIC. It sits directly downstream of the source synchronizers and samples each raw interrupt line. It applies the per-source trigger mode (level-high, level-low, rising edge, falling edge) and holds one pending request per source until the target claims and completes it. Edge-triggered sources count edges that arrive while a request is outstanding, so no edge is lost up to the counter depth.

## Interface
- NSRC, 8: number of interrupt sources; IDs are 1..NSRC, ID 0 means "none".
- CNT_W, 3: width of the per-source queued-edge counter; saturates at 2^CNT_W-1.
- ID_W, $clog2(NSRC+1): width of the claim/complete ID buses.

- pclk  in  1  clock
- preset_n  in  1  reset, asynchronous, active-low
- irq_src  in  NSRC  raw interrupt lines, already synchronized to pclk
- trig_mode  in  2*NSRC  per-source mode, bits [2i+1:2i]: 00 level-high, 01 level-low, 10 rising edge, 11 falling edge
- claim_vld  in  1  claim strobe, single cycle
- claim_id  in  ID_W  source being claimed
- complete_vld  in  1  complete strobe, single cycle
- complete_id  in  ID_W  source being completed
- ip  out  NSRC  pending bit per source, bit i means ID i+1
- ovf  out  NSRC  sticky: an edge was dropped because the counter was saturated

## Operation
- Per-source sample flop src_q <= irq_src[i]; it resets to 0.
- Per-source trigger, derived combinationally from irq_src and src_q:
  - level-high: irq_src
  - level-low: ~irq_src
  - rising: irq_src & ~src_q
  - falling: ~irq_src & src_q
- Per-source FSM with states IDLE, PEND, INFLIGHT. ip[i] = (state == PEND).
  - IDLE: trigger -> PEND.
  - PEND: a claim with matching ID -> INFLIGHT.
  - INFLIGHT: a complete with matching ID -> PEND if more work exists, else IDLE.
- Edge modes, counter cnt:
  - inc = trigger while in PEND or INFLIGHT.
  - On complete: more work exists when cnt+inc > 0. Go to PEND with cnt <= cnt+inc-1; otherwise go to IDLE.
  - Without a complete: cnt <= cnt+inc, saturating.
  - If inc occurs with cnt at maximum and no complete in the same cycle: cnt holds and ovf[i] <= 1.
- Level modes:
  - cnt is forced to 0.
  - On complete, go to PEND if the trigger is active in the complete cycle, else IDLE.
  - A level that drops while in PEND does not retract the request; ip stays set until claimed.
- Claim or complete to ID 0, ID > NSRC, or a source in the wrong state (claim while not PEND, complete while not INFLIGHT) is ignored. It changes no state and raises no error.
- claim and complete in the same cycle:
  - Different IDs: both take effect.
  - Same ID: only the one legal for the current state takes effect.
- Changing trig_mode mid-operation:
  - Does not clear the FSM state.
  - Takes effect in the detection of the same cycle.
  - cnt clears on the first cycle the mode is level.
- ovf clears only on reset.

## Timing
- Reset: ip = 0, ovf = 0, every FSM in IDLE, cnt = 0, src_q = 0.
- Reset-release artefacts, both required:
  - A source held high through reset in rising mode registers a rising edge on the first clock.
  - A level-low source that is low pends on the first clock.
- Trigger at cycle T: ip rises at T+1. The one-cycle latency comes from the registered FSM.
- Claim at T: ip falls at T+1.
- Complete at T with more work: ip rises at T+1. Minimum re-pend turnaround is 1 cycle after complete.
- Claim of a source whose ip first shows at T+1 must arrive at T+1 or later. A claim at T is ignored.
- Asserting preset_n mid-operation drops all pending, in-flight and counted edges immediately and asynchronously.

## Test plan
- Rising mode, NSRC=8: pulse irq_src[2] for 1 cycle -> ip[2]=1 on the next cycle. Claim ID 3 -> ip[2]=0. Complete ID 3 -> state IDLE, ip stays 0.
- Rising mode: 3 edges on src 0 while in INFLIGHT, then complete -> ip[0]=1, cnt=2. Two more claim/complete rounds -> pends each time. The final complete leaves IDLE.
- CNT_W=3: 9 edges while INFLIGHT -> cnt=7, ovf[0]=1. Exactly 8 total pend cycles follow (the in-flight one plus 7 queued).
- Level-high: hold src 5 high across complete -> re-pend 1 cycle after complete. Drop the level before complete -> IDLE after complete.
- Complete with cnt=0, edge arriving in the same cycle -> PEND, cnt=0. Claim and complete of the same ID in one cycle while INFLIGHT -> complete taken, claim ignored.
- Illegal IDs 0 and 9, claim of an IDLE source, complete of a PEND source -> no state change. Async reset while INFLIGHT with cnt=4 -> all outputs 0 with no clock edge needed.
